// File: rtl/sevenseg_scan_ctrl.sv
// Scan controller for a multiplexed seven-segment display.
// Payloads are double-buffered and swapped in only at frame boundaries.
module sevenseg_scan_ctrl #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_CYCLES = 100000,
  parameter int GUARD_CYCLES   = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    load_valid_i,
  output logic                    load_ready_o,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   digit_en_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  output logic [3:0]              nibble_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    dp_no,
  output logic                    frame_done_o
);

  localparam int CW = $clog2(REFRESH_CYCLES);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_CYCLES - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] GUARD   = CW'(GUARD_CYCLES);

  typedef enum logic [1:0] {
    BLANK,
    RUN,
    PEND
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] cnt_q;
  logic [IW-1:0] idx_q;

  logic [NUM_DIGITS-1:0][3:0] shadow_val_q;
  logic [NUM_DIGITS-1:0][3:0] pend_val_q;
  logic [NUM_DIGITS-1:0]      shadow_en_q;
  logic [NUM_DIGITS-1:0]      shadow_dp_q;
  logic [NUM_DIGITS-1:0]      pend_en_q;
  logic [NUM_DIGITS-1:0]      pend_dp_q;

  logic slot_end;
  logic fb;
  logic accept;
  logic commit;
  logic digit_on;

  assign slot_end     = (cnt_q == CNT_MAX);
  assign fb           = slot_end && (idx_q == IDX_MAX);
  assign frame_done_o = fb;
  assign load_ready_o = (state_q != PEND);
  assign accept       = load_valid_i && load_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (slot_end) begin
      cnt_q <= '0;
      idx_q <= (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BLANK;
    end else begin
      state_q <= state_d;
    end
  end

  // Commit only reads state_q, so a payload taken on an fb cycle
  // waits a full frame before it becomes visible.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    unique case (state_q)
      BLANK, RUN: begin
        if (accept) state_d = PEND;
      end
      PEND: begin
        if (fb) begin
          state_d = RUN;
          commit  = 1'b1;
        end
      end
      default: state_d = BLANK;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_val_q   <= '0;
      pend_en_q    <= '0;
      pend_dp_q    <= '0;
      shadow_val_q <= '0;
      shadow_en_q  <= '0;
      shadow_dp_q  <= '0;
    end else begin
      if (accept) begin
        pend_val_q <= value_i;
        pend_en_q  <= digit_en_i;
        pend_dp_q  <= dp_i;
      end
      if (commit) begin
        shadow_val_q <= pend_val_q;
        shadow_en_q  <= pend_en_q;
        shadow_dp_q  <= pend_dp_q;
      end
    end
  end

  always_comb begin
    digit_on = (state_q != BLANK) && shadow_en_q[idx_q] && (cnt_q >= GUARD);
    an_o     = '1;
    if (digit_on) an_o[idx_q] = 1'b0;
    dp_no    = ~(shadow_dp_q[idx_q] & digit_on);
    nibble_o = shadow_val_q[idx_q];
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl, 4 digits, 4-cycle slots, 1 guard.
// A scoreboard holds each payload with the frame it must first appear in.
module tb_sevenseg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        load_valid_i = 1'b0;
  logic        load_ready_o;
  logic [15:0] value_i = '0;
  logic [3:0]  digit_en_i = '0;
  logic [3:0]  dp_i = '0;
  logic [3:0]  nibble_o;
  logic [3:0]  an_o;
  logic        dp_no;
  logic        frame_done_o;

  sevenseg_scan_ctrl #(
    .NUM_DIGITS(4),
    .REFRESH_CYCLES(4),
    .GUARD_CYCLES(1)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .load_valid_i(load_valid_i),
    .load_ready_o(load_ready_o),
    .value_i(value_i),
    .digit_en_i(digit_en_i),
    .dp_i(dp_i),
    .nibble_o(nibble_o),
    .an_o(an_o),
    .dp_no(dp_no),
    .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          frame;
    logic [15:0] v;
    logic [3:0]  e;
    logic [3:0]  p;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail = 0;
  int t = 0;
  int pend_start = 0;
  int pend_end = 0;
  logic        blank = 1'b1;
  logic [15:0] d_val = '0;
  logic [3:0]  d_en = '0;
  logic [3:0]  d_dp = '0;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  task automatic check_cycle();
    int c = t % 4;
    int i = (t / 4) % 4;
    logic act;
    logic [3:0] an_e;
    logic rdy;
    act  = !blank && d_en[i] && (c >= 1);
    an_e = 4'hF;
    if (act) an_e[i] = 1'b0;
    rdy  = !(t >= pend_start && t < pend_end);
    chk("nibble", {12'h0, nibble_o}, {12'h0, d_val[i*4 +: 4]});
    chk("an", {12'h0, an_o}, {12'h0, an_e});
    chk("dp_n", {15'h0, dp_no}, {15'h0, ~(d_dp[i] & act)});
    chk("frame_done", {15'h0, frame_done_o}, {15'h0, (t % 16) == 15});
    chk("ready", {15'h0, load_ready_o}, {15'h0, rdy});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    t++;
    if (sb.size() > 0 && sb[0].frame * 16 == t) begin
      exp_t x;
      x     = sb.pop_front();
      d_val = x.v;
      d_en  = x.e;
      d_dp  = x.p;
      blank = 1'b0;
    end
    check_cycle();
  endtask

  task automatic run_to(input int n);
    while (t < n) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] e,
                         input logic [3:0] p);
    int f;
    value_i      = v;
    digit_en_i   = e;
    dp_i         = p;
    load_valid_i = 1'b1;
    f = t / 16 + 1 + (((t % 16) == 15) ? 1 : 0);
    sb.push_back('{f, v, e, p});
    pend_start = t + 1;
    pend_end   = f * 16;
    step();
    load_valid_i = 1'b0;
    value_i      = 16'($urandom);
    digit_en_i   = 4'($urandom);
    dp_i         = 4'($urandom);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", {12'h0, an_o}, 16'h000F);
    chk("rst_ready", {15'h0, load_ready_o}, 16'h0001);
    rst_ni = 1'b1;
    t = 0;
    check_cycle();

    run_to(20);
    do_load(16'h1234, 4'b1111, 4'b0100);
    run_to(24);
    load_valid_i = 1'b1;
    value_i      = 16'hEEEE;
    digit_en_i   = 4'b1111;
    dp_i         = 4'b1111;
    run_to(29);
    load_valid_i = 1'b0;

    run_to(54);
    do_load(16'hABCD, 4'b1111, 4'b0000);

    run_to(79);
    do_load(16'h00FF, 4'b1111, 4'b0001);

    run_to(100);
    do_load(16'h5678, 4'b0101, 4'b1010);

    run_to(134);
    do_load(16'h9999, 4'b1111, 4'b1111);

    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_an", {12'h0, an_o}, 16'h000F);
    chk("async_ready", {15'h0, load_ready_o}, 16'h0001);
    chk("async_dp_n", {15'h0, dp_no}, 16'h0001);
    chk("async_nibble", {12'h0, nibble_o}, 16'h0000);
    sb.delete();
    blank      = 1'b1;
    d_val      = '0;
    d_en       = '0;
    d_dp       = '0;
    pend_start = 0;
    pend_end   = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    t = 0;
    check_cycle();
    run_to(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
Time-multiplexing controller for the Basys3 4-digit seven-segment display. It owns a shadow copy of the displayed value and scans one digit per refresh slot. Each slot it presents that digit's nibble to the combinational hex-to-segment decoder and drives the active-low anode and decimal-point lines. New display values arrive over a valid/ready load handshake and are committed only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
NUM_DIGITS, 4, number of digits scanned (anodes)
REFRESH_CYCLES, 100000, clock cycles per digit slot (minimum 2)
GUARD_CYCLES, 2, anti-ghosting dead time at the start of each slot, in cycles (must be less than REFRESH_CYCLES)

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous, active-low reset
load_valid_i  input  1  new display payload offered
load_ready_o  output  1  controller can accept a payload
value_i  input  4*NUM_DIGITS  digit nibbles; digit k is value_i[4k+3:4k]
digit_en_i  input  NUM_DIGITS  per-digit enable, part of the payload
dp_i  input  NUM_DIGITS  per-digit decimal point, active-high, part of the payload
nibble_o  output  4  nibble for the current digit; feeds the decoder's d3..d0
an_o  output  NUM_DIGITS  anodes, active-low, at most one low at a time
dp_no  output  1  decimal point, active-low
frame_done_o  output  1  one-cycle pulse at the last cycle of a frame

Behaviour:
- Clock and reset: single clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Registers:
  - slot counter cnt, range 0..REFRESH_CYCLES-1
  - digit index idx, range 0..NUM_DIGITS-1
  - shadow value, enable and dp registers
  - pending value, enable and dp registers
  - state register
- Reset values: cnt=0, idx=0, shadow=0, pending=0, state=BLANK. Outputs after reset: an_o all 1, dp_no=1, nibble_o=0, load_ready_o=1, frame_done_o=0.
- Counting: cnt increments every cycle. When cnt==REFRESH_CYCLES-1, cnt wraps to 0 and idx increments. idx wraps from NUM_DIGITS-1 to 0. Scanning runs in every state.
- Frame boundary (fb) is the cycle where cnt==REFRESH_CYCLES-1 and idx==NUM_DIGITS-1. frame_done_o = fb, decoded combinationally from registers.
- States:
  - BLANK: after reset, no payload committed yet. All anodes stay high.
  - RUN: shadow registers are valid, no payload pending.
  - PEND: a payload is held in the pending registers, waiting for fb.
- load_ready_o = (state != PEND).
- Accept: load_valid_i and load_ready_o both high at a clock edge. The payload is copied into the pending registers and the state goes to PEND.
- Commit: in PEND at fb, pending is copied to shadow and the state goes to RUN. load_ready_o is high from the next cycle.
- A payload accepted on an fb cycle (from BLANK or RUN) is not committed at that fb; it commits at the following fb, one full frame later.
- load_valid_i held high while load_ready_o is low has no effect. The source must hold its payload stable until it is accepted.
- Output decode (combinational from registers only; no input-to-output paths):
  - nibble_o = shadow nibble[idx]
  - an_o[idx] = 0 only when state != BLANK, shadow_en[idx]=1 and cnt >= GUARD_CYCLES; every other anode bit is 1
  - dp_no = ~(shadow_dp[idx] and anode idx active)
- A disabled digit still advances through its slot; its anode simply stays high.
- Reset mid-frame or mid-PEND: the pending payload is discarded and the block returns to BLANK immediately, asynchronously.

Test Plan:
Run all scenarios with NUM_DIGITS=4, REFRESH_CYCLES=4, GUARD_CYCLES=1.
- Reset: hold rst_ni=0 for 3 cycles, release -> an_o=4'b1111, dp_no=1, load_ready_o=1. First frame_done_o pulse on cycle 15 after release, then every 16 cycles.
- First load: value_i=16'h1234, digit_en_i=4'b1111, dp_i=4'b0100, pulse valid mid-frame -> load_ready_o=0 until the next fb. In the following frame, per slot, an_o is 1111 for 1 cycle, then the active anode for 3 cycles: 1110 with nibble 4, 1101 with nibble 3, 1011 with nibble 2 and dp_no=0, 0111 with nibble 1.
- No tearing: in RUN, load 16'hABCD at cnt=2, idx=1 -> digits 2 and 3 still show 2 and 1. The first 'D' appears in slot 0 after the fb.
- Simultaneous accept and fb: assert valid with 16'h00FF exactly on an fb cycle -> accepted that cycle (ready drops the next cycle). The frame immediately after still shows the old value; 'F' appears only one frame later.
- Blanking: digit_en_i=4'b0101 -> an_o never drives bit 1 or bit 3 low, and slot timing is unchanged (frame_done_o period stays 16).
- Async reset in PEND: assert rst_ni=0 mid-cycle -> an_o=4'b1111 and load_ready_o=1 without waiting for a clock edge. The pending value never appears.
